// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if;
  logic        start;
  logic [3:0]  control;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] out1;
  logic [31:0] out2;
  logic        busy;
  logic        done;
  logic        z;
  logic        o;

  modport master (
    output start, control, in1, in2,
    input  out1, out2, busy, done, z, o
  );

  modport slave (
    input  start, control, in1, in2,
    output out1, out2, busy, done, z, o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide, one bit per cycle, results held until next FINISH.
// Optional build macro MULDIV_DIVZERO_EN: divide by zero finishes after one cycle with out1=out2=0, o=z=1.
module muldiv_unit (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave mdu
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        is_signed_q;
  logic        neg_a_q;
  logic        neg_b_q;
  logic        ovf_q;
  logic        divz_q;
  logic [31:0] opnd_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] out1_q;
  logic [31:0] out2_q;
  logic        busy_q;
  logic        done_q;
  logic        z_q;
  logic        o_q;

  logic        sgn_op_s;
  logic        div_op_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic        divz_s;

  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic        div_ge_s;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  logic [63:0] prod_raw_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] res1_s;
  logic [31:0] res2_s;
  logic        res_z_s;
  logic        res_o_s;

  // Magnitude of a two's complement word; 0x80000000 maps onto itself as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  assign sgn_op_s = mdu.control[1];
  assign div_op_s = mdu.control[0];
  assign neg_a_s  = sgn_op_s & mdu.in1[31];
  assign neg_b_s  = sgn_op_s & mdu.in2[31];
  assign abs_a_s  = abs32(mdu.in1, neg_a_s);
  assign abs_b_s  = abs32(mdu.in2, neg_b_s);

`ifdef MULDIV_DIVZERO_EN
  assign divz_s = div_op_s & (mdu.in2 == 32'd0);
`else
  assign divz_s = 1'b0;
`endif

  // One iteration: multiply shifts {hi,lo} right after a conditional add, divide shifts a quotient bit into lo.
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift_s = {hi_q, lo_q[31]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    if (is_div_q) begin
      if (div_ge_s) begin
        hi_d = div_shift_s[31:0] - opnd_q;
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = div_shift_s[31:0];
        lo_d = {lo_q[30:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum_s[32:1];
      lo_d = {mul_sum_s[0], lo_q[31:1]};
    end
  end

  // Sign fix-up and flag generation from the unsigned iteration result.
  always_comb begin
    prod_raw_s = {hi_q, lo_q};
    prod_s     = (neg_a_q ^ neg_b_q) ? (64'd0 - prod_raw_s) : prod_raw_s;
    quo_s      = (neg_a_q ^ neg_b_q) ? (32'd0 - lo_q) : lo_q;
    rem_s      = neg_a_q ? (32'd0 - hi_q) : hi_q;
    if (divz_q) begin
      res1_s  = 32'd0;
      res2_s  = 32'd0;
      res_z_s = 1'b1;
      res_o_s = 1'b1;
    end else if (is_div_q) begin
      res1_s  = quo_s;
      res2_s  = rem_s;
      res_z_s = (quo_s == 32'd0);
      res_o_s = ovf_q;
    end else begin
      res1_s  = prod_s[31:0];
      res2_s  = prod_s[63:32];
      res_z_s = (prod_s == 64'd0);
      if (is_signed_q) begin
        res_o_s = (prod_s[63:32] != {32{prod_s[31]}});
      end else begin
        res_o_s = (prod_s[63:32] != 32'd0);
      end
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      ovf_q       <= 1'b0;
      divz_q      <= 1'b0;
      opnd_q      <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      out1_q      <= 32'd0;
      out2_q      <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      z_q         <= 1'b0;
      o_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mdu.start && (mdu.control[3:2] == 2'b11)) begin
            is_div_q    <= div_op_s;
            is_signed_q <= sgn_op_s;
            neg_a_q     <= neg_a_s;
            neg_b_q     <= neg_b_s;
            ovf_q       <= sgn_op_s & div_op_s & (mdu.in1 == 32'h8000_0000)
                           & (mdu.in2 == 32'hFFFF_FFFF);
            divz_q      <= divz_s;
            opnd_q      <= div_op_s ? abs_b_s : abs_a_s;
            lo_q        <= div_op_s ? abs_a_s : abs_b_s;
            hi_q        <= 32'd0;
            cnt_q       <= 5'd31;
            busy_q      <= 1'b1;
            state_q     <= divz_s ? FINISH : RUN;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          out1_q  <= res1_s;
          out2_q  <= res2_s;
          z_q     <= res_z_s;
          o_q     <= res_o_s;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mdu.out1 = out1_q;
  assign mdu.out2 = out2_q;
  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.z    = z_q;
  assign mdu.o    = o_q;

endmodule
